// File: rtl/next_pc_pkg.sv
// Shared types and helpers for the next-PC generator and its redirect arbiter.
package next_pc_pkg;

  localparam int unsigned NUM_SRC_DEF = 4;
  localparam int unsigned PC_W_MAX    = 64;

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    RUN       = 2'd1,
    HOLD      = 2'd2,
    HOLD_PEND = 2'd3
  } state_t;

  typedef logic [$clog2(NUM_SRC_DEF)-1:0] src_idx_t;

  // Clears the low align_bits of an address held in a maximum-width container.
  function automatic logic [PC_W_MAX-1:0] align_clear(input logic [PC_W_MAX-1:0] addr,
                                                      input int unsigned         align_bits);
    logic [PC_W_MAX-1:0] mask;
    mask = ~((PC_W_MAX'(1) << align_bits) - PC_W_MAX'(1));
    return addr & mask;
  endfunction

endpackage

// File: rtl/next_pc_unit_redir_arbiter.sv
// Fixed-priority picker: the lowest set index wins; reports found flag, index and one-hot.
module redir_arbiter #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_SRC-1:0] valid,
  output logic               found,
  output logic [IDX_W-1:0]   idx,
  output logic [NUM_SRC-1:0] onehot
);

  always_comb begin
    found  = 1'b0;
    idx    = '0;
    onehot = '0;
    // Scan from the lowest priority upward so the lowest index overwrites last.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (valid[i]) begin
        found     = 1'b1;
        idx       = IDX_W'(i);
        onehot    = '0;
        onehot[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/next_pc_unit.sv
// Fetch-stage next-PC generator: sequential step or prioritised redirect, with stall
// handling that parks the best redirect seen while stalled.
//
// state     | meaning
// BOOT      | first cycle after reset, pc_o = RESET_PC not yet fetchable
// RUN       | advancing every unstalled cycle
// HOLD      | stalled, nothing pending
// HOLD_PEND | stalled, a redirect is parked in the pending registers
module next_pc_unit
  import next_pc_pkg::*;
#(
  parameter int unsigned     PC_W       = 32,
  parameter int unsigned     NUM_SRC    = 4,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int unsigned     ALIGN_BITS = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    stall_i,
  input  logic [NUM_SRC-1:0]      redir_valid_i,
  input  logic [NUM_SRC*PC_W-1:0] redir_target_i,
  output logic [PC_W-1:0]         pc_o,
  output logic [PC_W-1:0]         pc_inc_o,
  output logic                    pc_valid_o,
  output logic [NUM_SRC-1:0]      redir_taken_o,
  output logic                    misalign_o
);

  localparam int unsigned     IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PC_W-1:0] PC_STEP = PC_W'(1) << ALIGN_BITS;

  state_t             state;
  logic               pend_valid;
  logic [IDX_W-1:0]   pend_idx;
  logic [PC_W-1:0]    pend_target;

  logic [NUM_SRC-1:0] pend_onehot;
  logic [NUM_SRC-1:0] merged;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [NUM_SRC-1:0] win_onehot;
  logic               win_live;
  logic [PC_W-1:0]    live_target;
  logic [PC_W-1:0]    win_target;
  logic [PC_W-1:0]    win_aligned;
  logic               win_misalign;
  logic [PC_W_MAX-1:0] target_ext;
  logic [PC_W_MAX-1:0] aligned_ext;

  assign pc_inc_o = pc_o + PC_STEP;

  always_comb begin
    pend_onehot = '0;
    if (pend_valid) pend_onehot[pend_idx] = 1'b1;
  end

  // Pending and live requests share one picker: if the winning index has a live
  // request it came from (or ties with) a live source, so the live source wins.
  assign merged = redir_valid_i | pend_onehot;

  redir_arbiter #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_arb (
    .valid  (merged),
    .found  (win_found),
    .idx    (win_idx),
    .onehot (win_onehot)
  );

  assign win_live    = redir_valid_i[win_idx];
  assign live_target = redir_target_i[win_idx*PC_W +: PC_W];
  assign win_target  = win_live ? live_target : pend_target;

  always_comb begin
    target_ext           = '0;
    target_ext[PC_W-1:0] = win_target;
    aligned_ext          = align_clear(target_ext, ALIGN_BITS);
    win_aligned          = aligned_ext[PC_W-1:0];
    win_misalign         = (win_aligned != win_target);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      pc_o          <= RESET_PC;
      pc_valid_o    <= 1'b0;
      redir_taken_o <= '0;
      misalign_o    <= 1'b0;
      pend_valid    <= 1'b0;
      pend_idx      <= '0;
      pend_target   <= '0;
    end else begin
      case (state)
        BOOT: begin
          state      <= RUN;
          pc_valid_o <= 1'b1;
        end
        RUN, HOLD, HOLD_PEND: begin
          if (stall_i) begin
            // Pending target is kept raw so misalign is judged when it is applied.
            if (win_found && win_live) begin
              pend_valid  <= 1'b1;
              pend_idx    <= win_idx;
              pend_target <= live_target;
              state       <= HOLD_PEND;
            end else if (state == RUN) begin
              state <= HOLD;
            end
          end else begin
            pend_valid <= 1'b0;
            state      <= RUN;
            if (win_found) begin
              pc_o          <= win_aligned;
              redir_taken_o <= win_onehot;
              misalign_o    <= win_misalign;
            end else begin
              pc_o          <= pc_inc_o;
              redir_taken_o <= '0;
              misalign_o    <= 1'b0;
            end
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// Self-checking bench for next_pc_unit: directed vector table, random run against a
// behavioural model, and an asynchronous reset taken while a redirect is pending.
module tb_next_pc_unit;
  import next_pc_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         stall;
  logic [3:0]   valid;
  logic [127:0] tgt;
  logic [31:0]  pc;
  logic [31:0]  pc_inc;
  logic         pc_valid;
  logic [3:0]   taken;
  logic         mis;

  int checks   = 0;
  int failures = 0;

  next_pc_unit #(
    .PC_W       (32),
    .NUM_SRC    (4),
    .RESET_PC   (32'h0000_0000),
    .ALIGN_BITS (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_i        (stall),
    .redir_valid_i  (valid),
    .redir_target_i (tgt),
    .pc_o           (pc),
    .pc_inc_o       (pc_inc),
    .pc_valid_o     (pc_valid),
    .redir_taken_o  (taken),
    .misalign_o     (mis)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         stall;
    logic [3:0]   valid;
    logic [127:0] tgt;
    logic [31:0]  exp_pc;
    logic [3:0]   exp_taken;
    logic         exp_mis;
  } vec_t;

  vec_t vecs[22];

  // Behavioural model state
  logic        m_boot;
  logic [31:0] m_pc;
  logic        m_valid;
  logic [3:0]  m_taken;
  logic        m_mis;
  logic        m_pv;
  src_idx_t    m_pidx;
  logic [31:0] m_pt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] slot(input int k, input logic [31:0] t);
    logic [127:0] r;
    r = '0;
    r[k*32 +: 32] = t;
    return r;
  endfunction

  function automatic vec_t mk(input logic s, input logic [3:0] v, input logic [127:0] t,
                              input logic [31:0] p, input logic [3:0] tk, input logic ms);
    vec_t r;
    r.stall = s; r.valid = v; r.tgt = t;
    r.exp_pc = p; r.exp_taken = tk; r.exp_mis = ms;
    return r;
  endfunction

  task automatic model_reset();
    m_boot = 1'b0; m_pc = 32'h0; m_valid = 1'b0; m_taken = 4'h0; m_mis = 1'b0;
    m_pv = 1'b0; m_pidx = '0; m_pt = 32'h0;
  endtask

  // Spec rules directly: lowest live index beats pending when its index is <= pending.
  task automatic model_step(input logic st, input logic [3:0] v, input logic [127:0] t);
    int li;
    logic [31:0] dst;
    if (!m_boot) begin
      m_boot = 1'b1;
      m_valid = 1'b1;
      return;
    end
    li = -1;
    for (int k = 0; k < 4; k++) if (v[k] && li < 0) li = k;
    if (st) begin
      if (li >= 0 && (!m_pv || li <= int'(m_pidx))) begin
        m_pv = 1'b1; m_pidx = src_idx_t'(li); m_pt = t[li*32 +: 32];
      end
    end else begin
      if (li >= 0 && (!m_pv || li <= int'(m_pidx))) begin
        dst = t[li*32 +: 32];
        m_pc = {dst[31:2], 2'b00}; m_taken = 4'h1 << li; m_mis = (dst[1:0] != 2'b00);
      end else if (m_pv) begin
        m_pc = {m_pt[31:2], 2'b00}; m_taken = 4'h1 << m_pidx; m_mis = (m_pt[1:0] != 2'b00);
      end else begin
        m_pc = m_pc + 32'd4; m_taken = 4'h0; m_mis = 1'b0;
      end
      m_pv = 1'b0;
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " pc"}, pc, m_pc);
    chk({tag, " pc_inc"}, pc_inc, m_pc + 32'd4);
    chk({tag, " pc_valid"}, {31'h0, pc_valid}, {31'h0, m_valid});
    chk({tag, " taken"}, {28'h0, taken}, {28'h0, m_taken});
    chk({tag, " misalign"}, {31'h0, mis}, {31'h0, m_mis});
  endtask

  // Entered and left on a falling edge.
  task automatic rstep(input logic st, input logic [3:0] v, input logic [127:0] t, input string tag);
    stall = st; valid = v; tgt = t;
    model_step(st, v, t);
    @(posedge clk);
    #1;
    compare_model(tag);
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = mk(1'b1, 4'b0001, slot(0, 32'h999), 32'h0, 4'b0000, 1'b0);
    vecs[1]  = mk(1'b0, 4'b0000, '0, 32'h4, 4'b0000, 1'b0);
    vecs[2]  = mk(1'b0, 4'b0000, '0, 32'h8, 4'b0000, 1'b0);
    vecs[3]  = mk(1'b0, 4'b0000, '0, 32'hC, 4'b0000, 1'b0);
    vecs[4]  = mk(1'b0, 4'b1010, slot(1, 32'h100) | slot(3, 32'h200), 32'h100, 4'b0010, 1'b0);
    vecs[5]  = mk(1'b0, 4'b0000, '0, 32'h104, 4'b0000, 1'b0);
    vecs[6]  = mk(1'b0, 4'b0100, slot(2, 32'h40), 32'h40, 4'b0100, 1'b0);
    vecs[7]  = mk(1'b1, 4'b0100, slot(2, 32'h300), 32'h40, 4'b0100, 1'b0);
    vecs[8]  = mk(1'b1, 4'b0001, slot(0, 32'h80), 32'h40, 4'b0100, 1'b0);
    vecs[9]  = mk(1'b1, 4'b0000, '0, 32'h40, 4'b0100, 1'b0);
    vecs[10] = mk(1'b0, 4'b0000, '0, 32'h80, 4'b0001, 1'b0);
    vecs[11] = mk(1'b0, 4'b0010, slot(1, 32'h103), 32'h100, 4'b0010, 1'b1);
    vecs[12] = mk(1'b0, 4'b0000, '0, 32'h104, 4'b0000, 1'b0);
    vecs[13] = mk(1'b0, 4'b0001, slot(0, 32'hFFFF_FFFC), 32'hFFFF_FFFC, 4'b0001, 1'b0);
    vecs[14] = mk(1'b0, 4'b0000, '0, 32'h0, 4'b0000, 1'b0);
    vecs[15] = mk(1'b1, 4'b0010, slot(1, 32'h600), 32'h0, 4'b0000, 1'b0);
    vecs[16] = mk(1'b1, 4'b1000, slot(3, 32'h700), 32'h0, 4'b0000, 1'b0);
    vecs[17] = mk(1'b0, 4'b0000, '0, 32'h600, 4'b0010, 1'b0);
    vecs[18] = mk(1'b1, 4'b0100, slot(2, 32'h800), 32'h600, 4'b0010, 1'b0);
    vecs[19] = mk(1'b0, 4'b0100, slot(2, 32'h900), 32'h900, 4'b0100, 1'b0);
    vecs[20] = mk(1'b1, 4'b0000, '0, 32'h900, 4'b0100, 1'b0);
    vecs[21] = mk(1'b0, 4'b0000, '0, 32'h904, 4'b0000, 1'b0);

    rst_n = 1'b0; stall = 1'b0; valid = '0; tgt = '0;
    #12;
    chk("reset pc", pc, 32'h0);
    chk("reset pc_valid", {31'h0, pc_valid}, 32'h0);
    chk("reset taken", {28'h0, taken}, 32'h0);
    chk("reset misalign", {31'h0, mis}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("boot pc_valid low", {31'h0, pc_valid}, 32'h0);

    for (int i = 0; i < 22; i++) begin
      stall = vecs[i].stall; valid = vecs[i].valid; tgt = vecs[i].tgt;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d pc_inc", i), pc_inc, vecs[i].exp_pc + 32'd4);
      chk($sformatf("vec%0d pc_valid", i), {31'h0, pc_valid}, 32'h1);
      chk($sformatf("vec%0d taken", i), {28'h0, taken}, {28'h0, vecs[i].exp_taken});
      chk($sformatf("vec%0d misalign", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
      @(negedge clk);
    end

    // Random run against the model
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_model("rand reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 400; n++) begin
      logic [3:0] v;
      for (int k = 0; k < 4; k++) v[k] = ($urandom_range(0, 3) == 0);
      rstep(($urandom_range(0, 2) == 0), v,
            {$urandom(), $urandom(), $urandom(), $urandom()}, $sformatf("rand%0d", n));
    end

    // Asynchronous reset while a redirect to 0x500 is parked
    rstep(1'b0, 4'b0001, slot(0, 32'h1230), "mid redir");
    rstep(1'b1, 4'b0010, slot(1, 32'h500), "mid capture");
    rstep(1'b1, 4'b0000, '0, "mid hold");
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async reset pc", pc, 32'h0);
    chk("async reset pc_valid", {31'h0, pc_valid}, 32'h0);
    chk("async reset taken", {28'h0, taken}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      rstep(1'b0, 4'b0000, '0, $sformatf("post%0d", n));
      checks++;
      if (pc === 32'h500) begin
        failures++;
        $display("FAIL post%0d stale pending actual=%h required=not 00000500", n, pc);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/next_pc_unit.md
# next_pc_unit

Parametrised next-PC generator with its own PC register. Each cycle it picks between sequential increment and up to NUM_SRC prioritised redirect sources (exception, jump, branch, ...). It also handles fetch stall and keeps a redirect that arrives during a stall. It sits at the front of the fetch stage and replaces the fixed two-way jump/sequential select of the single-cycle datapath.

## Interface
- PC_W, 32: PC width in bits.
- NUM_SRC, 4: number of redirect sources; index 0 is highest priority.
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- ALIGN_BITS, 2: low PC bits that must be zero; the increment is 2**ALIGN_BITS.

- clk, input, 1: sole clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- stall_i, input, 1: hold the current PC this cycle.
- redir_valid_i, input, NUM_SRC: per-source redirect request.
- redir_target_i, input, NUM_SRC*PC_W: packed targets; source k occupies bits [k*PC_W +: PC_W].
- pc_o, output, PC_W: current fetch PC (registered).
- pc_inc_o, output, PC_W: pc_o + 2**ALIGN_BITS, combinational, wraps modulo 2**PC_W.
- pc_valid_o, output, 1: pc_o is a fetchable address.
- redir_taken_o, output, NUM_SRC: registered one-hot; shows which source produced the current pc_o. All zero for a sequential step.
- misalign_o, output, 1: registered; the redirect that produced pc_o had nonzero low bits.

## Operation
- Reset values: pc_o = RESET_PC, pc_valid_o = 0, redir_taken_o = 0, misalign_o = 0, pending cleared, state BOOT.
- **States:**
  - BOOT: pc_valid_o = 0. On the next edge, go to RUN, with pc_o unchanged (RESET_PC) and pc_valid_o = 1. Redirects and stall are ignored in BOOT.
  - RUN, stall_i = 0: advance pc_o (see *Advance*). If stall_i = 1, hold pc_o. If a redirect is also valid that cycle, capture it and go to HOLD_PEND; otherwise go to HOLD.
  - HOLD: pc_o holds. A valid redirect is captured and moves the state to HOLD_PEND. When stall_i = 0, advance and go to RUN.
  - HOLD_PEND: pc_o holds. A new redirect replaces the pending one only if its source index is ≤ the pending index. When stall_i = 0, advance and go to RUN, and clear pending.
- **Advance:** the winner is the lowest-index valid live source, compared against pending (if any) by index. A tie goes to the live source.
  - With a winner: pc_o = target with its ALIGN_BITS low bits cleared; redir_taken_o = one-hot of the winner; misalign_o = OR of the original low bits.
  - With no winner: pc_o = pc_inc_o; redir_taken_o = 0; misalign_o = 0.
- During a hold, redir_taken_o and misalign_o hold their last values.
- Sequential increment wraps: (2**PC_W − 2**ALIGN_BITS) → 0, with no flag.
- Reset asserted mid-operation, including HOLD_PEND, returns immediately to reset values. The pending redirect is discarded.

## Timing
- Redirect to pc_o latency: 1 cycle when unstalled. When stalled, pc_o updates 1 cycle after stall_i falls.
- redir_taken_o and misalign_o change on the same edge as pc_o.
- pc_inc_o is combinational from pc_o only. There is no input-to-output combinational path.
- Stall has priority over redirect for the PC update. A redirect is never lost while stalled; only a lower-priority one can be superseded.
- pc_valid_o rises on the first edge after rst_n deasserts. It stays high until the next reset.

## Structure
- Shared package next_pc_pkg holds:
  - the state enum (BOOT, RUN, HOLD, HOLD_PEND);
  - the source-index type of width $clog2(NUM_SRC);
  - helper function align_clear.
- Sub-module redir_arbiter: a combinational fixed-priority picker over NUM_SRC valid bits. It outputs a found flag, an index and a one-hot vector. The same picker also serves the pending-replace comparison.
- Top level holds: pc register, pending target/index/valid registers, state register, output registers.

## Test plan
- **Reset/boot:** release rst_n → pc_o = 0 with pc_valid_o = 0 for 1 cycle, then 0 with valid = 1. The next cycles give 4, 8, 0xC.
- **Priority:** sources 1 and 3 both valid, targets 0x100 and 0x200, unstalled → pc_o = 0x100, redir_taken_o = 4'b0010.
- **Stall capture:**
  - Stall for 3 cycles with pc_o = 0x40; source 2 pulses target 0x300 in stall cycle 1, then source 0 pulses 0x80 in cycle 2.
  - Release → pc_o = 0x80, redir_taken_o = 4'b0001. pc_o holds 0x40 throughout the stall.
- **Misalign:** source 1 target 0x103 → pc_o = 0x100, misalign_o = 1 for that PC. On the next sequential step → 0x104, misalign_o = 0.
- **Wrap:** start from a redirect to 0xFFFF_FFFC, unstalled → next pc_o = 0x0 with no flags.
- **Reset mid-hold:** in HOLD_PEND with pending 0x500, assert rst_n low asynchronously → pc_o = 0 immediately. After release, boot proceeds and 0x500 never appears.
